// File: rtl/arb_pkg.sv
// Shared definitions for the shared-port arbiter: FSM state encoding,
// default sizing constants and a small index helper.
package arb_pkg;

    // Arbiter FSM: IDLE (port free) or OWNED (one requester holds the port).
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int ARB_NUM_REQ_DEF  = 4;
    localparam int ARB_MAX_HOLD_DEF = 16;

    // Index after 'idx' in a ring of 'n' entries (n-1 wraps to 0).
    function automatic int arb_wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector. Searches ptr, ptr+1, ... modulo
// NUM_REQ and returns the first index whose req bit survives the mask.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic [NUM_REQ-1:0]         mask,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   pos;
    int                 sum;

    assign cand = req & mask;

    // Walk the ring from the far end back to ptr so the nearest candidate wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        sum   = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = int'(ptr) + off;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            pos = IDX_W'(sum);
            if (cand[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/shared_port_arbiter.sv
// Round-robin, grant-locking arbiter for one multi-cycle shared port.
// A granted requester keeps the port until it pulses its release bit; the
// pointer then moves just past it and the next winner can be granted at the
// same edge (back-to-back handoff).
// Optional feature: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// owned cycles, flagged by a one-cycle 'timeout' pulse.
// The release input is named 'rel' because 'release' is a reserved word.
//
// Handshake: req is a level held by each requester; gnt answers one edge
// later and stays locked to the owner; the owner ends the grant with a
// single-cycle rel pulse, and gnt changes at that same edge.
module shared_port_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         rel,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner_idx,
    output arb_state_e                 state_dbg,
    output logic [$clog2(NUM_REQ)-1:0] ptr_dbg
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                       timeout
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MAX_HOLD < 1) begin : g_bad_param
        $error("shared_port_arbiter: NUM_REQ must be >= 2 and MAX_HOLD >= 1");
    end

    arb_state_e         state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [IDX_W-1:0]   owner_n, ptr, ptr_n, ptr_inc, pick_ptr, pick_idx;
    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_valid, owner_rel, forced, end_grant;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              timeout_n;

    // Force a release once the owner has used its last allowed cycle,
    // unless it releases on its own at that same edge.
    assign forced = (state == OWNED) && !owner_rel
                    && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign forced = 1'b0;
`endif

    assign owner_rel = (state == OWNED) && rel[owner_idx];
    assign end_grant = owner_rel | forced;
    assign ptr_inc   = IDX_W'(arb_wrap_inc(int'(owner_idx), NUM_REQ));

    // On a release the search starts past the old owner and skips it, so the
    // handoff sees the updated pointer in the same cycle.
    assign pick_ptr  = end_grant ? ptr_inc : ptr;
    assign pick_mask = end_grant ? ~(NUM_REQ'(1) << owner_idx) : '1;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state logic: grant from IDLE, hold or hand off from OWNED.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner_idx;
        ptr_n   = ptr;
`ifdef ARB_TIMEOUT_EN
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (en && pick_valid) begin
                    state_n = OWNED;
                    gnt_n   = NUM_REQ'(1) << pick_idx;
                    owner_n = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    hold_n  = '0;
`endif
                end
            end
            OWNED: begin
                if (end_grant) begin
                    ptr_n = ptr_inc;
`ifdef ARB_TIMEOUT_EN
                    timeout_n = forced;
                    hold_n    = '0;
`endif
                    if (en && pick_valid) begin
                        gnt_n   = NUM_REQ'(1) << pick_idx;
                        owner_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_n = hold_cnt + 1'b1;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            owner_idx <= '0;
            ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            owner_idx <= owner_n;
            ptr       <= ptr_n;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_n;
            timeout   <= timeout_n;
`endif
        end
    end

    assign busy      = |gnt;
    assign state_dbg = state;
    assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Self-checking bench for shared_port_arbiter (NUM_REQ = 4). Builds with or
// without ARB_TIMEOUT_EN; with it defined the DUT uses MAX_HOLD = 4.
module tb_shared_port_arbiter;
    import arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam int MH = 4;
`else
    localparam int MH = 16;
`endif

    logic       clock;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner_idx;
    arb_state_e state_dbg;
    logic [1:0] ptr_dbg;
    logic       timeout_obs;

    shared_port_arbiter #(.NUM_REQ(4), .MAX_HOLD(MH)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .busy      (busy),
        .owner_idx (owner_idx),
        .state_dbg (state_dbg),
        .ptr_dbg   (ptr_dbg)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout   (timeout_obs)
`endif
    );

`ifndef ARB_TIMEOUT_EN
    assign timeout_obs = 1'b0;
`endif

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_owned;
    bit m_to;
    int m_owner;
    int m_ptr;
    int m_hold;

    function automatic int rr_search(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic e, input logic [3:0] r, input logic [3:0] rl);
        bit hit;
        bit frc;
        int w;
        m_to = 1'b0;
        frc  = 1'b0;
        if (rst) begin
            m_owned = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owned) begin
            hit = rl[m_owner];
`ifdef ARB_TIMEOUT_EN
            frc = !hit && (m_hold == MH - 1);
`endif
            if (hit || frc) begin
                m_ptr = (m_owner + 1) % 4;
                m_to  = frc;
                m_hold = 0;
                w = rr_search(r, m_ptr, m_owner);
                if (e && w >= 0) m_owner = w;
                else m_owned = 1'b0;
            end else begin
                m_hold++;
            end
        end else if (e) begin
            w = rr_search(r, m_ptr, -1);
            if (w >= 0) begin
                m_owned = 1'b1;
                m_owner = w;
                m_hold  = 0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    // Packed expectation: {timeout, ptr[1:0], owner[1:0], busy, gnt[3:0]}
    logic [9:0] exp_q[$];

    task automatic apply(input logic rst, input logic e, input logic [3:0] r, input logic [3:0] rl);
        logic [9:0] x;
        logic [3:0] g;
        reset = rst;
        en    = e;
        req   = r;
        rel   = rl;
        model_step(rst, e, r, rl);
        g = m_owned ? (4'b0001 << m_owner) : 4'b0000;
        exp_q.push_back({m_to, 2'(m_ptr), 2'(m_owner), m_owned, g});
        @(posedge clock);
        #1;
        x = exp_q.pop_front();
        check_eq("gnt", gnt, x[3:0]);
        check_eq("busy", busy, x[4]);
        check_eq("state", state_dbg, x[4]);
        check_eq("owner_idx", owner_idx, x[6:5]);
        check_eq("ptr", ptr_dbg, x[8:7]);
        check_eq("timeout", timeout_obs, x[9]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        en    = 1'b0;
        req   = '0;
        rel   = '0;
        @(negedge clock);

        // Reset and quiet bus.
        apply(1, 0, 4'b0000, 4'b0000);
        apply(1, 0, 4'b0000, 4'b0000);
        check_eq("reset_gnt", gnt, 4'b0000);
        for (int i = 0; i < 5; i++) apply(0, 1, 4'b0000, 4'b0000);

        // Simple grant then back-to-back handoff.
        apply(0, 1, 4'b1010, 4'b0000);
        check_eq("first_grant", gnt, 4'b0010);
        apply(0, 1, 4'b1010, 4'b0010);
        check_eq("handoff_gnt", gnt, 4'b1000);
        check_eq("handoff_ptr", ptr_dbg, 2'd2);
        apply(0, 1, 4'b0000, 4'b1000);

        // Four continuous requesters, each releasing on its third owned cycle.
        apply(0, 1, 4'b1111, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            check_eq("rr_order", owner_idx, 32'(k % 4));
            apply(0, 1, 4'b1111, 4'b0000);
            apply(0, 1, 4'b1111, 4'b0000);
            apply(0, 1, 4'b1111, 4'b0001 << (k % 4));
            check_eq("no_idle", busy, 1'b1);
        end
        apply(0, 1, 4'b0000, 4'b0010);

        // Owner drops req, non-owner pulses release: grant stays.
        apply(0, 1, 4'b0100, 4'b0000);
        apply(0, 1, 4'b0000, 4'b0001);
        apply(0, 1, 4'b0000, 4'b0001);
        check_eq("grant_lock", gnt, 4'b0100);
        apply(0, 1, 4'b0000, 4'b0100);

        // en low during ownership, then release with only the owner requesting.
        apply(0, 1, 4'b0001, 4'b0000);
        apply(0, 0, 4'b0001, 4'b0000);
        apply(0, 0, 4'b0001, 4'b0000);
        apply(0, 0, 4'b0001, 4'b0001);
        check_eq("en_low_gnt", gnt, 4'b0000);
        check_eq("en_low_busy", busy, 1'b0);
        apply(0, 1, 4'b0001, 4'b0000);
        check_eq("en_back_gnt", gnt, 4'b0001);
        apply(0, 1, 4'b0000, 4'b0001);

        // Reset in the middle of a grant.
        apply(0, 1, 4'b0010, 4'b0000);
        apply(1, 1, 4'b0010, 4'b0000);
        check_eq("midreset_gnt", gnt, 4'b0000);
        check_eq("midreset_ptr", ptr_dbg, 2'd0);
        apply(0, 0, 4'b0000, 4'b0000);

`ifdef ARB_TIMEOUT_EN
        // Owner 3 never releases: forced handoff to 0 with ptr wrap.
        apply(0, 1, 4'b1000, 4'b0000);
        for (int i = 0; i < 4; i++) apply(0, 1, 4'b1001, 4'b0000);
        check_eq("to_pulse", timeout_obs, 1'b1);
        check_eq("to_gnt", gnt, 4'b0001);
        check_eq("to_ptr", ptr_dbg, 2'd0);
        apply(0, 1, 4'b1001, 4'b0000);
        check_eq("to_single", timeout_obs, 1'b0);
        apply(0, 1, 4'b0000, 4'b0001);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic e;
            logic [3:0] r;
            logic [3:0] rl;
            logic rst;
            e   = ($urandom_range(0, 3) != 0);
            r   = 4'($urandom_range(0, 15));
            rl  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rst = ($urandom_range(0, 99) == 0);
            apply(rst, e, r, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
